// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I subset core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port and drives
// the datapath muxes and strobes. It also keeps a retired-instruction counter
// and a memory watchdog that halts the core when an ack never arrives.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_opcode                      inst[6:0] from the instruction register
//   i_br_taken                    branch comparator result (used in EXEC)
//   i_mem_ack                     memory completion / read data valid
//   o_mem_req/o_mem_we/o_addr_sel memory handshake and address mux
//   o_ir_we                       instruction register load
//   o_imm_sel                     immediate select (registered in DECODE)
//   o_alu_a_sel/o_alu_b_sel       ALU operand muxes
//   o_rd_wren/o_wb_sel            register-file write and writeback source
//   o_pc_we/o_pc_sel              PC update strobe and next-PC select
//   o_illegal/o_bus_err           one-cycle error pulses
//   o_halted                      sticky halt after a bus error
//   o_instret                     retired-instruction count
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [6:0]       i_opcode,
   input  logic             i_br_taken,
   input  logic             i_mem_ack,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_addr_sel,
   output logic             o_ir_we,
   output logic [1:0]       o_imm_sel,
   output logic             o_alu_a_sel,
   output logic             o_alu_b_sel,
   output logic             o_rd_wren,
   output logic             o_wb_sel,
   output logic             o_pc_we,
   output logic             o_pc_sel,
   output logic             o_illegal,
   output logic             o_bus_err,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_instret
);

   localparam int unsigned WD_W = 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH
   } cls_t;

   state_t          state_q, state_d;
   cls_t            cls_q, cls_c;
   logic            legal_c;
   logic [1:0]      imm_c;
   logic [1:0]      imm_sel_q;
   logic [WD_W-1:0] wd_q;
   logic [CNT_W-1:0] instret_q;

   logic mem_req, mem_we, addr_sel, ir_we, alu_a, alu_b, rd_wren, wb_sel;
   logic pc_we, pc_sel, illegal, bus_err;

   // Opcode classification and immediate format
   always_comb begin
      cls_c   = C_OP;
      legal_c = 1'b1;
      imm_c   = 2'b00;
      case (i_opcode)
         OPC_OP:     cls_c = C_OP;
         OPC_OPIMM:  cls_c = C_OPIMM;
         OPC_LOAD:   cls_c = C_LOAD;
         OPC_STORE:  begin cls_c = C_STORE;  imm_c = 2'b01; end
         OPC_BRANCH: begin cls_c = C_BRANCH; imm_c = 2'b10; end
         default:    legal_c = 1'b0;
      endcase
   end

   // State, decoded class, immediate select, watchdog and retire counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_FETCH;
         cls_q     <= C_OP;
         imm_sel_q <= 2'b00;
         wd_q      <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            cls_q     <= cls_c;
            imm_sel_q <= imm_c;
         end
         // Watchdog restarts on every state change (entry to FETCH/MEM) and on ack
         if (state_d != state_q || i_mem_ack)
            wd_q <= '0;
         else if (mem_req)
            wd_q <= wd_q + WD_W'(1);
         if (pc_we && !illegal)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Next state and datapath controls
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      alu_a    = 1'b0;
      alu_b    = 1'b0;
      rd_wren  = 1'b0;
      wb_sel   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (i_mem_ack) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wd_q == WD_LAST) begin
               bus_err = 1'b1;
               state_d = S_HALT;
            end
         end
         S_DECODE: begin
            if (!legal_c) begin
               illegal = 1'b1;
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               C_OP:    state_d = S_WB;
               C_OPIMM: begin alu_b = 1'b1; state_d = S_WB; end
               C_LOAD, C_STORE: begin alu_b = 1'b1; state_d = S_MEM; end
               C_BRANCH: begin
                  alu_a   = 1'b1;
                  alu_b   = 1'b1;
                  pc_we   = 1'b1;
                  pc_sel  = i_br_taken;
                  state_d = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (cls_q == C_STORE);
            if (i_mem_ack) begin
               if (cls_q == C_STORE) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wd_q == WD_LAST) begin
               bus_err = 1'b1;
               state_d = S_HALT;
            end
         end
         S_WB: begin
            rd_wren = 1'b1;
            wb_sel  = (cls_q == C_LOAD);
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are forced low while reset is held so FETCH cannot request during reset
   assign o_mem_req   = mem_req  & ~i_rst;
   assign o_mem_we    = mem_we   & ~i_rst;
   assign o_addr_sel  = addr_sel & ~i_rst;
   assign o_ir_we     = ir_we    & ~i_rst;
   assign o_alu_a_sel = alu_a    & ~i_rst;
   assign o_alu_b_sel = alu_b    & ~i_rst;
   assign o_rd_wren   = rd_wren  & ~i_rst;
   assign o_wb_sel    = wb_sel   & ~i_rst;
   assign o_pc_we     = pc_we    & ~i_rst;
   assign o_pc_sel    = pc_sel   & ~i_rst;
   assign o_illegal   = illegal  & ~i_rst;
   assign o_bus_err   = bus_err  & ~i_rst;
   assign o_imm_sel   = imm_sel_q;
   assign o_halted    = (state_q == S_HALT);
   assign o_instret   = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I subset core. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port. It drives the immediate-generator select, ALU operand muxes, register-file write, PC update and memory handshake. It also keeps a retired-instruction counter and a memory-timeout watchdog that halts the core on a hung bus.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ack before bus error (range 2..255)
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_opcode  input  7  opcode field from instruction register (inst[6:0])
i_br_taken  input  1  branch comparator result, valid in EXEC
i_mem_ack  input  1  memory completion; read data valid in the ack cycle
o_mem_req  output  1  memory request, held until ack
o_mem_we  output  1  memory write enable, valid with o_mem_req
o_addr_sel  output  1  memory address mux: 0=PC, 1=ALU result
o_ir_we  output  1  instruction register load
o_imm_sel  output  2  immediate select: 00=I, 01=S, 10=B
o_alu_a_sel  output  1  0=rs1, 1=PC
o_alu_b_sel  output  1  0=rs2, 1=immediate
o_rd_wren  output  1  register-file write enable
o_wb_sel  output  1  writeback: 0=ALU, 1=memory data
o_pc_we  output  1  PC update strobe
o_pc_sel  output  1  next PC: 0=PC+4, 1=ALU (branch target)
o_illegal  output  1  one-cycle pulse on unsupported opcode
o_bus_err  output  1  one-cycle pulse on memory timeout
o_halted  output  1  sticky halt flag
o_instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, i_rst=1): state=FETCH, o_imm_sel=00, o_instret=0, o_halted=0, timeout counter=0. All strobes are 0 while reset is asserted. FETCH then asserts o_mem_req in the first cycle after release.
- Supported opcodes:
  - OP 0110011
  - OP-IMM 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - Anything else is illegal.
- States and transitions:
  - FETCH: o_mem_req=1, o_mem_we=0, o_addr_sel=0. Wait for i_mem_ack. In the ack cycle, o_ir_we=1, then go to DECODE.
  - DECODE: register o_imm_sel from i_opcode: LOAD/OP-IMM/OP→00, STORE→01, BRANCH→10.
    - Illegal opcode: o_illegal=1, o_pc_we=1, o_pc_sel=0, then go to FETCH. o_instret does not increment.
    - Otherwise go to EXEC.
  - EXEC: operand selects are combinational on state+opcode.
    - OP: a=0, b=0, go to WB.
    - OP-IMM: a=0, b=1, go to WB.
    - LOAD/STORE: a=0, b=1 (address calculation), go to MEM.
    - BRANCH: a=1, b=1 (PC+B-imm target), o_pc_we=1, o_pc_sel=i_br_taken, retire, go to FETCH.
  - MEM: o_mem_req=1, o_addr_sel=1, o_mem_we=1 for STORE only. In the ack cycle:
    - LOAD: go to WB.
    - STORE: o_pc_we=1, o_pc_sel=0, retire, go to FETCH.
  - WB: o_rd_wren=1, o_wb_sel=1 for LOAD and 0 otherwise, o_pc_we=1, o_pc_sel=0, retire, go to FETCH.
  - HALT: all strobes 0, o_halted=1. Exit only by reset.
- Latency with ack in the first request cycle:
  - OP/OP-IMM: 4 cycles
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- o_imm_sel holds its value from DECODE until the next DECODE. It never takes 11.
- Memory handshake:
  - o_mem_req, o_mem_we and o_addr_sel stay constant until the ack cycle. Request drops the cycle after ack.
  - An ack while o_mem_req=0 is ignored.
- Watchdog:
  - The counter clears on entry to FETCH/MEM and on ack. It increments each request cycle without ack.
  - When it reaches MEM_TIMEOUT-1 with no ack: o_bus_err=1 for one cycle, then go to HALT.
  - An ack arriving in that same final cycle wins: normal completion, no error.
- Retire:
  - o_instret increments by 1 on every o_pc_we cycle except the illegal one.
  - It wraps modulo 2^CNT_W.
- Reset mid-operation: immediately abandons any outstanding request (o_mem_req=0). No pc_we or rd_wren is issued.

Test Plan:
1. Reset, then OP-IMM (opcode 0010011) with ack in the first cycle → FETCH/DECODE/EXEC/WB. o_rd_wren=1 only in cycle 4, o_alu_b_sel=1, o_imm_sel=00, o_instret=1.
2. STORE with mem ack delayed 3 cycles → o_mem_req=1, o_mem_we=1, o_addr_sel=1 for 4 cycles. o_imm_sel=01, no o_rd_wren, o_pc_we on the ack cycle.
3. BRANCH with i_br_taken=1, then a second BRANCH with i_br_taken=0 → o_imm_sel=10, o_pc_sel=1 then 0 in EXEC. o_instret=2 after both.
4. Opcode 1111111 → o_illegal is a 1-cycle pulse in DECODE with o_pc_we=1, o_instret unchanged, FETCH follows.
5. MEM_TIMEOUT=16, never ack in FETCH → o_bus_err pulse in the 16th request cycle, then o_halted=1 with all strobes 0. An ack on cycle 16 instead completes normally.
6. Assert i_rst during a LOAD's MEM wait → o_mem_req drops immediately, no rd_wren. After release the FSM restarts at FETCH with o_instret=0.
